// File: rtl/frame_pad_counter.sv
// frame_pad_counter: forwards NUM beats per frame, pads to FRAME_LEN, then flags done
module frame_pad_counter #(
  parameter int BIT_WIDTH = 32,
  parameter int N_CH = 1,
  parameter int NUM = 784,
  parameter int FRAME_LEN = 1024,
  parameter int PAD_MODE = 0,
  parameter logic [BIT_WIDTH-1:0] PAD_VALUE = '0,
  localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      clr,
  input  logic [N_CH*BIT_WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N_CH*BIT_WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      done,
  output logic [CNT_W-1:0]          beat_cnt
);
  typedef enum logic [2:0] {IDLE, PASS, PAD, DRAIN, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(NUM - 1);
  localparam logic [CNT_W-1:0] LAST_F = CNT_W'(FRAME_LEN - 1);
  state_t state, state_n;
  logic [N_CH*BIT_WIDTH-1:0] hold, pad;
  logic load, acc, pad_ld, idle_like, drain_ok;
  assign load = !out_valid || out_ready;
  assign in_ready = state == PASS && load && !clr;
  assign acc = in_valid && in_ready;
  assign pad_ld = state == PAD && load;
  assign idle_like = state == IDLE || state == DONE;
  assign drain_ok = state == DRAIN && out_valid && out_ready && out_last;
  assign pad = PAD_MODE == 1 ? hold : PAD_MODE == 2 ? {N_CH{PAD_VALUE}} : '0;
  always_comb begin
    state_n = state;
    if (clr) state_n = IDLE;
    else if (idle_like && start) state_n = PASS;
    else if (acc && beat_cnt == LAST_D) state_n = FRAME_LEN > NUM ? PAD : DRAIN;
    else if (pad_ld && beat_cnt == LAST_F) state_n = DRAIN;
    else if (drain_ok) state_n = DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // a beat already in the register but not yet taken is dropped on clr
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_data <= '0; out_valid <= 1'b0; out_last <= 1'b0;
      done <= 1'b0; beat_cnt <= '0; hold <= '0;
    end else if (clr) begin
      out_valid <= 1'b0; out_last <= 1'b0; done <= 1'b0; beat_cnt <= '0;
    end else begin
      if (idle_like && start) begin done <= 1'b0; beat_cnt <= '0; end
      if (acc || pad_ld) begin
        out_data <= acc ? in_data : pad;
        out_valid <= 1'b1;
        out_last <= beat_cnt == LAST_F;
        beat_cnt <= beat_cnt + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0; out_last <= 1'b0;
      end
      if (acc) hold <= in_data;
      if (drain_ok) done <= 1'b1;
    end
endmodule

// File: tb/tb_frame_pad_counter.sv
// tb_frame_pad_counter: four configurations driven in lockstep, checked against a frame-level model
module tb_frame_pad_counter;
  logic clk = 0, rst = 1, start = 0, clr = 0, in_valid = 0, out_ready = 1;
  logic [15:0] in_data = '0;
  logic [15:0] od [4];
  logic ov [4], ol [4], dn [4], ir [4];
  logic [2:0] bc [4];
  int checks = 0, failures = 0, cyc = 0, t0 = 0;
  bit tog = 0, acc = 0;
  logic [15:0] dat [4];
  logic [15:0] e1 [6] = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h0, 16'h0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // dut0: zero pad, dut1: repeat last, dut2: constant 0xFF, dut3: no padding
  for (genvar g = 0; g < 4; g++) begin : g_dut
    frame_pad_counter #(.BIT_WIDTH(8), .N_CH(2), .NUM(4), .FRAME_LEN(g == 3 ? 4 : 6),
                        .PAD_MODE(g == 1 ? 1 : g == 2 ? 2 : 0), .PAD_VALUE(8'hFF)) u_dut (
      .clk(clk), .rst(rst), .start(start), .clr(clr), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir[g]), .out_data(od[g]), .out_valid(ov[g]), .out_ready(out_ready),
      .out_last(ol[g]), .done(dn[g]), .beat_cnt(bc[g]));
  end
  function automatic int fl_of(input int i);
    return i == 3 ? 4 : 6;
  endfunction
  function automatic logic [15:0] pad_of(input int i, input logic [15:0] last);
    return i == 1 ? last : i == 2 ? 16'hFFFF : 16'h0000;
  endfunction
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, i, act, exp);
    end
  endtask
  logic [15:0] ex [4][8], lg [4][8], hd [4];
  int ocnt [4], nd [4], lc [4];
  bit run [4], fin [4], hv [4];
  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (rst) begin
        run[i] = 0; fin[i] = 0; hv[i] = 0; ocnt[i] = 0; nd[i] = 0;
      end else begin
        if (hv[i]) begin
          chk("hold_valid", i, 32'(ov[i]), 1);
          chk("hold_data", i, 32'(od[i]), 32'(hd[i]));
        end
        chk("done", i, 32'(dn[i]), 32'(fin[i]));
        if (!run[i]) chk("idle_valid", i, 32'(ov[i]), 0);
        if (!run[i] || nd[i] == 4) chk("in_ready_low", i, 32'(ir[i]), 0);
        if (run[i] && ov[i]) chk("last", i, 32'(ol[i]), 32'(ocnt[i] == fl_of(i) - 1));
        hv[i] = ov[i] && !out_ready && !clr;
        hd[i] = od[i];
        if (clr) begin
          run[i] = 0; fin[i] = 0; hv[i] = 0;
        end else if (start && !run[i]) begin
          run[i] = 1; fin[i] = 0; ocnt[i] = 0; nd[i] = 0; lc[i] = 0;
        end else if (run[i]) begin
          if (ov[i] && out_ready) begin
            chk("data", i, 32'(od[i]), 32'(ex[i][ocnt[i]]));
            lg[i][lc[i]] = od[i]; lc[i]++; ocnt[i]++;
            if (ocnt[i] == fl_of(i)) begin run[i] = 0; fin[i] = 1; end
          end
          if (in_valid && ir[i]) begin
            ex[i][nd[i]] = in_data; nd[i]++;
            if (nd[i] == 4) for (int p = 4; p < fl_of(i); p++) ex[i][p] = pad_of(i, in_data);
          end
        end
      end
  task automatic step();
    @(negedge clk);
    acc = in_valid && ir[0];
    @(posedge clk);
    #1;
    if (tog) out_ready = !out_ready;
  endtask
  task automatic begin_frame();
    start = 1; in_valid = 1; in_data = dat[0];
    step();
    start = 0; t0 = cyc;
  endtask
  task automatic feed(input int n);
    int k = 0, g = 0;
    while (k < n && g < 40) begin
      step(); g++;
      if (acc) k++;
      in_data = dat[k < 4 ? k : 3];
      in_valid = k < n;
    end
    if (k < n) chk("feed_timeout", 0, 32'(k), 32'(n));
  endtask
  task automatic wait_done();
    int g = 0;
    while (!(dn[0] && dn[1] && dn[2] && dn[3]) && g < 60) begin step(); g++; end
    chk("done_timeout", 0, 32'(dn[0] && dn[1] && dn[2] && dn[3]), 1);
  endtask
  task automatic set_dat(input logic [15:0] a, b, c, d);
    dat[0] = a; dat[1] = b; dat[2] = c; dat[3] = d;
  endtask
  initial begin
    set_dat(16'h1, 16'h2, 16'h3, 16'h4);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", i, 32'(ov[i]), 0);
      chk("rst_cnt", i, 32'(bc[i]), 0);
      chk("rst_ready", i, 32'(ir[i]), 0);
    end
    rst = 0;
    step();
    begin_frame(); feed(4); wait_done();
    chk("t1_latency", 0, 32'(cyc - t0), 7);
    for (int j = 0; j < 6; j++) chk("t1_seq", 0, 32'(lg[0][j]), 32'(e1[j]));
    chk("t1_cnt", 0, 32'(bc[0]), 6);
    chk("t4_beats", 3, 32'(lc[3]), 4);
    chk("t4_cnt", 3, 32'(bc[3]), 4);
    chk("t4_ready", 3, 32'(ir[3]), 0);
    tog = 1;
    begin_frame(); feed(4); wait_done();
    tog = 0; out_ready = 1;
    for (int j = 0; j < 6; j++) chk("t2_seq", 0, 32'(lg[0][j]), 32'(e1[j]));
    chk("t2_cnt", 0, 32'(bc[0]), 6);
    set_dat(16'h0101, 16'h0202, 16'h0303, 16'h0709);
    begin_frame(); feed(4); wait_done();
    chk("t3_rep4", 1, 32'(lg[1][4]), 32'h0709);
    chk("t3_rep5", 1, 32'(lg[1][5]), 32'h0709);
    chk("t3_const4", 2, 32'(lg[2][4]), 32'hFFFF);
    chk("t3_const5", 2, 32'(lg[2][5]), 32'hFFFF);
    chk("t3_zero5", 0, 32'(lg[0][5]), 0);
    set_dat(16'h1, 16'h2, 16'h3, 16'h4);
    begin_frame(); feed(2);
    out_ready = 0;
    chk("t5_held_valid", 0, 32'(ov[0]), 1);
    chk("t5_held_data", 0, 32'(od[0]), 32'h2);
    clr = 1;
    step();
    clr = 0; out_ready = 1;
    chk("t5_clr_valid", 0, 32'(ov[0]), 0);
    chk("t5_clr_cnt", 0, 32'(bc[0]), 0);
    chk("t5_clr_ready", 0, 32'(ir[0]), 0);
    begin_frame(); feed(4); wait_done();
    for (int j = 0; j < 6; j++) chk("t5_seq", 0, 32'(lg[0][j]), 32'(e1[j]));
    begin_frame(); feed(4); step();
    chk("t6_pad_cnt", 0, 32'(bc[0]), 5);
    #2 rst = 1;
    #1;
    chk("t6_rst_data", 0, 32'(od[0]), 0);
    chk("t6_rst_valid", 0, 32'(ov[0]), 0);
    chk("t6_rst_last", 0, 32'(ol[0]), 0);
    chk("t6_rst_cnt", 0, 32'(bc[0]), 0);
    step(); step();
    rst = 0;
    begin_frame(); feed(4); wait_done();
    clr = 1; start = 1;
    step();
    clr = 0; start = 0;
    chk("t6_cs_done", 0, 32'(dn[0]), 0);
    chk("t6_cs_cnt", 0, 32'(bc[0]), 0);
    step();
    chk("t6_cs_idle", 0, 32'(ir[0]), 0);
    chk("t6_cs_done2", 0, 32'(dn[0]), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
